// File: rtl/prga_cfg_pkg.sv
// Shared types and elaboration-time helpers for the tile programming chain.
// Contents:
//   cfg_state_e          - segment state (PROG while loading, LOCKED once frozen)
//   clog2(v)             - ceil(log2(v)), 0 for v <= 1
//   cfg_depth(num, w)    - words needed to hold num bits at w bits per word
package prga_cfg_pkg;

  typedef enum logic {
    PROG   = 1'b0,
    LOCKED = 1'b1
  } cfg_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cfg_depth(input int num, input int w);
    return (num + w - 1) / w;
  endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Configuration shift register plus downstream output capture for one tile.
// Optional macro: CFG_READBACK_EN adds the rot input, which recirculates the
// bottom word to the top instead of loading din.
// Ports:
//   clk, rst_n  - programming clock, async active-low reset
//   shift       - advance the register by one word
//   rot         - (CFG_READBACK_EN only) rotate instead of load
//   din         - word entering at the top
//   sr          - full register contents, including padding bits
//   dout        - word that left the bottom on the last shift (held otherwise)
//   we_o        - registered copy of shift for the downstream segment
module cfg_shift_reg #(
  parameter int DEPTH   = 384,
  parameter int CHAIN_W = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       shift,
`ifdef CFG_READBACK_EN
  input  logic                       rot,
`endif
  input  logic [CHAIN_W-1:0]         din,
  output logic [DEPTH*CHAIN_W-1:0]   sr,
  output logic [CHAIN_W-1:0]         dout,
  output logic                       we_o
);

  localparam int SR_W = DEPTH * CHAIN_W;

  logic [SR_W-1:0] sr_ld;
`ifdef CFG_READBACK_EN
  logic [SR_W-1:0] sr_rot;
`endif

  // A single-word register has no "upper part" to slice, so it gets its own
  // next-value form.
  generate
    if (DEPTH == 1) begin : g_one
      assign sr_ld  = din;
`ifdef CFG_READBACK_EN
      assign sr_rot = sr;
`endif
    end else begin : g_many
      assign sr_ld  = {din, sr[SR_W-1:CHAIN_W]};
`ifdef CFG_READBACK_EN
      assign sr_rot = {sr[CHAIN_W-1:0], sr[SR_W-1:CHAIN_W]};
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      dout <= '0;
      we_o <= 1'b0;
    end else begin
      we_o <= shift;
      if (shift) begin
        dout <= sr[CHAIN_W-1:0];
`ifdef CFG_READBACK_EN
        sr   <= rot ? sr_rot : sr_ld;
`else
        sr   <= sr_ld;
`endif
      end
    end
  end

endmodule

// File: rtl/cfg_chain_seg.sv
// One tile's segment of the configuration programming chain. Words shift in
// from upstream, overflow words pass through to downstream, and once
// prog_done freezes the fabric the segment reports whether it was fully
// loaded.
// Optional macro: CFG_READBACK_EN adds prog_rb; shifts with prog_rb=1 rotate
// the tile contents out without disturbing them or the word count.
// Ports:
//   prog_clk, prog_rst_n  - programming clock, async active-low reset
//   prog_done             - programming finished, freezes configuration
//   prog_we, prog_din     - upstream shift strobe and word
//   prog_rb               - (CFG_READBACK_EN only) readback rotate select
//   prog_dout, prog_we_o  - registered word and strobe to downstream
//   cfg_q                 - configuration bits to tile logic
//   cfg_valid, cfg_err    - locked with full / short load
//
// state  | meaning
// PROG   | accepting shifts, counting words loaded
// LOCKED | prog_done high, configuration frozen, flags valid
module cfg_chain_seg
  import prga_cfg_pkg::*;
#(
  parameter int NUM_CFG = 384,
  parameter int CHAIN_W = 1
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic                prog_done,
  input  logic                prog_we,
  input  logic [CHAIN_W-1:0]  prog_din,
`ifdef CFG_READBACK_EN
  input  logic                prog_rb,
`endif
  output logic [CHAIN_W-1:0]  prog_dout,
  output logic                prog_we_o,
  output logic [NUM_CFG-1:0]  cfg_q,
  output logic                cfg_valid,
  output logic                cfg_err
);

  localparam int DEPTH = cfg_depth(NUM_CFG, CHAIN_W);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam int SR_W  = DEPTH * CHAIN_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  cfg_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  sr;
  logic             shift;
  logic             load;

  assign shift = prog_we & ~prog_done;

  // Only shifts that bring in a fresh word count towards the load.
`ifdef CFG_READBACK_EN
  assign load = shift & ~prog_rb;
`else
  assign load = shift;
`endif

  cfg_shift_reg #(
    .DEPTH   (DEPTH),
    .CHAIN_W (CHAIN_W)
  ) u_sr (
    .clk   (prog_clk),
    .rst_n (prog_rst_n),
    .shift (shift),
`ifdef CFG_READBACK_EN
    .rot   (prog_rb),
`endif
    .din   (prog_din),
    .sr    (sr),
    .dout  (prog_dout),
    .we_o  (prog_we_o)
  );

  assign cfg_q = sr[NUM_CFG-1:0];

  generate
    if (SR_W > NUM_CFG) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^sr[SR_W-1:NUM_CFG];
    end
  endgenerate

  // Flags are set on the edge that enters LOCKED so they appear one edge
  // after prog_done changes; cnt cannot move while LOCKED.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state     <= PROG;
      cnt       <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        PROG: begin
          if (prog_done) begin
            state     <= LOCKED;
            cfg_valid <= (cnt == DEPTH_C);
            cfg_err   <= (cnt != DEPTH_C);
          end else if (load && (cnt != DEPTH_C)) begin
            cnt <= cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (!prog_done) begin
            state     <= PROG;
            cnt       <= '0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
          end
        end
        default: begin
          state <= PROG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_chain_seg.sv
module tb_cfg_chain_seg;

  localparam int NUM_CFG = 8;
  localparam int CHAIN_W = 3;

  logic               prog_clk;
  logic               prog_rst_n;
  logic               prog_done;
  logic               prog_we;
  logic [CHAIN_W-1:0] prog_din;
  logic               prog_rb;
  logic [CHAIN_W-1:0] prog_dout;
  logic               prog_we_o;
  logic [NUM_CFG-1:0] cfg_q;
  logic               cfg_valid;
  logic               cfg_err;

  cfg_chain_seg #(
    .NUM_CFG (NUM_CFG),
    .CHAIN_W (CHAIN_W)
  ) dut (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .prog_done  (prog_done),
    .prog_we    (prog_we),
    .prog_din   (prog_din),
`ifdef CFG_READBACK_EN
    .prog_rb    (prog_rb),
`endif
    .prog_dout  (prog_dout),
    .prog_we_o  (prog_we_o),
    .cfg_q      (cfg_q),
    .cfg_valid  (cfg_valid),
    .cfg_err    (cfg_err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: three 3-bit words, word 0 at the bottom (next to leave).
  logic [2:0] mw [3];
  logic [2:0] last_dout;
  logic [2:0] exp_q [$];

  typedef struct {
    logic       we;
    logic [2:0] din;
    logic       done;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_cfgq;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_cfgq();
    logic [8:0] full;
    full = {mw[2], mw[1], mw[0]};
    return full[7:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) mw[i] = 3'b000;
    last_dout = 3'b000;
    exp_q.delete();
  endtask

  task automatic do_reset();
    prog_rst_n = 1'b0;
    prog_we = 1'b0; prog_done = 1'b0; prog_din = '0; prog_rb = 1'b0;
    repeat (2) @(posedge prog_clk);
    #3 prog_rst_n = 1'b1;
    model_clear();
    @(posedge prog_clk); #1;
  endtask

  // One clock: drive, take the edge, update the reference, check the strobe
  // and any scoreboarded output word.
  task automatic cycle(input logic we, input logic [2:0] din, input logic done, input logic rb);
    logic sh;
    logic rb_eff;
    logic [2:0] w0;
    prog_we = we; prog_din = din; prog_done = done; prog_rb = rb;
`ifdef CFG_READBACK_EN
    rb_eff = rb;
`else
    rb_eff = 1'b0;
`endif
    @(posedge prog_clk); #1;
    sh = we & ~done;
    if (sh) begin
      w0 = mw[0];
      exp_q.push_back(w0);
      mw[0] = mw[1];
      mw[1] = mw[2];
      mw[2] = rb_eff ? w0 : din;
    end
    chk("prog_we_o", prog_we_o, sh);
    if (prog_we_o) begin
      if (exp_q.size() == 0) begin
        chk("dout_unexpected", 1, 0);
      end else begin
        chk("prog_dout", prog_dout, exp_q.pop_front());
        last_dout = prog_dout;
      end
    end else begin
      chk("dout_hold", prog_dout, last_dout);
    end
  endtask

  logic [2:0] w [5];
  logic [7:0] q_before;

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 8'h40};
    vecs[1] = '{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 8'hA8};
    vecs[2] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 8'hD5};
    vecs[3] = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 8'hD5};
    vecs[4] = '{1'b1, 3'b011, 1'b1, 1'b1, 1'b0, 8'hD5};

    // Reset state
    prog_rst_n = 1'b0;
    model_clear();
    do_reset();
    chk("rst_cfg_q", cfg_q, 8'h00);
    chk("rst_dout", prog_dout, 3'b000);
    chk("rst_we_o", prog_we_o, 1'b0);
    chk("rst_valid", cfg_valid, 1'b0);
    chk("rst_err", cfg_err, 1'b0);

    // Asynchronous reset in the middle of a load
    cycle(1'b1, 3'b110, 1'b0, 1'b0);
    cycle(1'b1, 3'b011, 1'b0, 1'b0);
    cycle(1'b1, 3'b101, 1'b0, 1'b0);
    chk("pre_rst_cfg_q", cfg_q, 8'h5E);
    #2 prog_rst_n = 1'b0;
    #1;
    chk("async_cfg_q", cfg_q, 8'h00);
    chk("async_dout", prog_dout, 3'b000);
    chk("async_we_o", prog_we_o, 1'b0);
    chk("async_valid", cfg_valid, 1'b0);
    chk("async_err", cfg_err, 1'b0);
    do_reset();
    chk("post_rst_cfg_q", cfg_q, 8'h00);

    // Table-driven load, lock and freeze attempt
    for (int i = 0; i < 5; i++) begin
      cycle(vecs[i].we, vecs[i].din, vecs[i].done, 1'b0);
      chk($sformatf("vec%0d_cfg_q", i), cfg_q, vecs[i].exp_cfgq);
      chk($sformatf("vec%0d_valid", i), cfg_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_err", i), cfg_err, vecs[i].exp_err);
    end

`ifdef CFG_READBACK_EN
    // Readback: unlock, rotate DEPTH times, contents must survive
    cycle(1'b0, 3'b000, 1'b0, 1'b0);
    chk("rb_unlock_valid", cfg_valid, 1'b0);
    cycle(1'b1, 3'b000, 1'b0, 1'b1);
    chk("rb_dout0", prog_dout, 3'b101);
    cycle(1'b1, 3'b110, 1'b0, 1'b1);
    chk("rb_dout1", prog_dout, 3'b010);
    cycle(1'b1, 3'b001, 1'b0, 1'b1);
    chk("rb_dout2", prog_dout, 3'b111);
    chk("rb_cfg_q", cfg_q, 8'hD5);
    // Rotations do not count as loaded words
    cycle(1'b0, 3'b000, 1'b1, 1'b0);
    chk("rb_relock_err", cfg_err, 1'b1);
    chk("rb_relock_valid", cfg_valid, 1'b0);
`endif

    // Pass-through: five words into a three-word segment
    do_reset();
    for (int i = 0; i < 5; i++) w[i] = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) cycle(1'b1, w[i], 1'b0, 1'b0);
    cycle(1'b1, w[3], 1'b0, 1'b0);
    chk("pt_dout_w0", prog_dout, w[0]);
    cycle(1'b1, w[4], 1'b0, 1'b0);
    chk("pt_dout_w1", prog_dout, w[1]);
    chk("pt_cfg_q", cfg_q, model_cfgq());
    cycle(1'b0, 3'b000, 1'b1, 1'b0);
    chk("pt_sat_valid", cfg_valid, 1'b1);
    chk("pt_sat_err", cfg_err, 1'b0);

    // Underfill then relock with a full load
    cycle(1'b0, 3'b000, 1'b0, 1'b0);
    chk("uf_unlock_valid", cfg_valid, 1'b0);
    chk("uf_unlock_err", cfg_err, 1'b0);
    cycle(1'b1, 3'b001, 1'b0, 1'b0);
    cycle(1'b1, 3'b010, 1'b0, 1'b0);
    cycle(1'b0, 3'b000, 1'b1, 1'b0);
    chk("uf_err", cfg_err, 1'b1);
    chk("uf_valid", cfg_valid, 1'b0);
    cycle(1'b0, 3'b000, 1'b0, 1'b0);
    cycle(1'b1, 3'b100, 1'b0, 1'b0);
    cycle(1'b1, 3'b000, 1'b0, 1'b0);
    cycle(1'b1, 3'b011, 1'b0, 1'b0);
    chk("relock_cfg_q", cfg_q, 8'hC4);
    cycle(1'b0, 3'b000, 1'b1, 1'b0);
    chk("relock_valid", cfg_valid, 1'b1);
    chk("relock_err", cfg_err, 1'b0);

    // Freeze: strobes while locked must be ignored
    q_before = cfg_q;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
      chk("frz_cfg_q", cfg_q, q_before);
      chk("frz_valid", cfg_valid, 1'b1);
    end

    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
